pc_fetch_ctrl: RTL

Fetch-stage program counter controller; it consumes the taken-redirect (`PcSel`) and target (`BrPC`) produced by the EX-stage branch unit. It holds the architectural fetch PC, advances it by 4 each unstalled cycle, and applies redirects for taken branches, JAL and JALR. It raises flush strobes for the IF/ID and ID/EX pipeline registers and halts fetch on an illegal target. It drives the instruction-memory address and the `Cur_PC` that travels down the pipeline.

---
 rtl/pc_fetch_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC controller: sequential +4 advance, EX-stage redirects, halt on illegal target.
// Latency: redirect or increment visible one edge after sampling; flush strobes are combinational.
// Backpressure: stall holds the PC unless a redirect is taken, and a redirect always overrides stall.
module pc_fetch_ctrl #(
  parameter int          PC_W     = 9,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            misalign_err,
  output logic            range_err,
  output logic [15:0]     redirect_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t state;
  logic   tgt_misalign;
  logic   tgt_range;
  logic   flush;

  assign tgt_misalign = |redirect_pc[1:0];
  // Bits at or above PC_W lie outside the instruction address space.
  assign tgt_range    = |(redirect_pc >> PC_W);

  // Flush for illegal targets as well, so wrong-path instructions never retire.
  assign flush      = (state == RUN) && redirect_valid;
  assign flush_ifid = flush;
  assign flush_idex = flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= BOOT;
      pc             <= RESET_PC[PC_W-1:0];
      pc_valid       <= 1'b0;
      misalign_err   <= 1'b0;
      range_err      <= 1'b0;
      redirect_count <= 16'h0000;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (redirect_valid && !tgt_misalign && !tgt_range) begin
            pc <= redirect_pc[PC_W-1:0];
            if (redirect_count != 16'hFFFF) begin
              redirect_count <= redirect_count + 16'h0001;
            end
          end else if (redirect_valid) begin
            state    <= HALT;
            pc_valid <= 1'b0;
            if (tgt_misalign) misalign_err <= 1'b1;
            if (tgt_range)    range_err    <= 1'b1;
          end else if (!stall) begin
            pc <= pc + PC_W'(4);
          end
        end
        HALT: begin
          pc_valid <= 1'b0;
        end
        default: begin
          state    <= HALT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
